// File: rtl/fall_qualifier.sv
// Fall signature qualifier: free-fall, impact, then stillness.
// Holds fall_sensor high on a confirmed fall until clear or reset.
module fall_qualifier #(
  parameter int MAG_W         = 12,
  parameter int FF_TH         = 200,
  parameter int IMPACT_TH     = 2500,
  parameter int ONE_G         = 1000,
  parameter int STILL_BAND    = 300,
  parameter int FF_MIN        = 8,
  parameter int IMPACT_WIN    = 50,
  parameter int STILL_SAMPLES = 200,
  parameter int STILL_WIN     = 400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [MAG_W-1:0] accel_mag,
  input  logic             clear,
  output logic             fall_sensor,
  output logic [7:0]       fall_count,
  output logic [2:0]       state
);

  localparam int FF_W = $clog2(FF_MIN + 1);
  localparam int WN_W = $clog2(IMPACT_WIN + 1);
  localparam int SC_W = $clog2(STILL_SAMPLES + 1);
  localparam int ST_W = $clog2(STILL_WIN + 1);

  localparam int LO_I = (ONE_G > STILL_BAND) ? ONE_G - STILL_BAND : 0;
  localparam int HI_I = ONE_G + STILL_BAND;

  localparam logic [MAG_W-1:0] FF_TH_C  = MAG_W'(FF_TH);
  localparam logic [MAG_W-1:0] IMP_TH_C = MAG_W'(IMPACT_TH);
  localparam logic [MAG_W:0]   STILL_LO = (MAG_W + 1)'(LO_I);
  localparam logic [MAG_W:0]   STILL_HI = (MAG_W + 1)'(HI_I);
  localparam logic [FF_W-1:0]  FF_MIN_C = FF_W'(FF_MIN);
  localparam logic [WN_W-1:0]  WIN_C    = WN_W'(IMPACT_WIN);
  localparam logic [SC_W-1:0]  SC_C     = SC_W'(STILL_SAMPLES);
  localparam logic [ST_W-1:0]  ST_C     = ST_W'(STILL_WIN);

  if (!(FF_TH < LO_I && HI_I < IMPACT_TH)) begin : g_bad_thresholds
    $error("fall_qualifier: thresholds overlap the still band");
  end

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_FREEFALL    = 3'd1,
    S_IMPACT_WAIT = 3'd2,
    S_STILL_CHECK = 3'd3,
    S_FALL        = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [FF_W-1:0] ff_cnt_q, ff_cnt_d;
  logic [WN_W-1:0] win_cnt_q, win_cnt_d;
  logic [SC_W-1:0] still_cnt_q, still_cnt_d;
  logic [ST_W-1:0] still_tot_q, still_tot_d;
  logic [7:0]      fall_count_q, fall_count_d;
  logic            fall_sensor_q, fall_sensor_d;

  logic            is_ff, is_impact, is_still;
  logic [WN_W-1:0] win_inc;
  logic [SC_W-1:0] sc_next;
  logic [ST_W-1:0] tot_inc;

  // Sample classification against the three magnitude regions
  always_comb begin
    is_ff     = accel_mag < FF_TH_C;
    is_impact = accel_mag >= IMP_TH_C;
    is_still  = ({1'b0, accel_mag} >= STILL_LO) &&
                ({1'b0, accel_mag} <= STILL_HI);
  end

  // Next-state and counter update; clear overrides any sample
  always_comb begin
    state_d      = state_q;
    ff_cnt_d     = ff_cnt_q;
    win_cnt_d    = win_cnt_q;
    still_cnt_d  = still_cnt_q;
    still_tot_d  = still_tot_q;
    fall_count_d = fall_count_q;
    win_inc      = win_cnt_q + 1'b1;
    tot_inc      = still_tot_q + 1'b1;
    sc_next      = is_still ? still_cnt_q + 1'b1 : '0;
    if (clear) begin
      state_d     = S_IDLE;
      ff_cnt_d    = '0;
      win_cnt_d   = '0;
      still_cnt_d = '0;
      still_tot_d = '0;
    end else if (sample_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_ff) begin
            ff_cnt_d = FF_W'(1);
            state_d  = S_FREEFALL;
          end
        end
        S_FREEFALL: begin
          if (is_ff) begin
            if (ff_cnt_q < FF_MIN_C) ff_cnt_d = ff_cnt_q + 1'b1;
          end else if (ff_cnt_q < FF_MIN_C) begin
            state_d = S_IDLE;
          end else if (is_impact) begin
            state_d     = S_STILL_CHECK;
            still_cnt_d = '0;
            still_tot_d = '0;
          end else begin
            state_d   = S_IMPACT_WAIT;
            win_cnt_d = WN_W'(1);
          end
        end
        S_IMPACT_WAIT: begin
          if (is_impact) begin
            state_d     = S_STILL_CHECK;
            still_cnt_d = '0;
            still_tot_d = '0;
          end else begin
            win_cnt_d = win_inc;
            if (win_inc == WIN_C) state_d = S_IDLE;
          end
        end
        S_STILL_CHECK: begin
          still_tot_d = tot_inc;
          still_cnt_d = sc_next;
          if (sc_next == SC_C) begin
            state_d = S_FALL;
            if (fall_count_q != 8'hFF) fall_count_d = fall_count_q + 8'd1;
          end else if (tot_inc == ST_C) begin
            state_d = S_IDLE;
          end
        end
        S_FALL: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
    fall_sensor_d = (state_d == S_FALL);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ff_cnt_q      <= '0;
      win_cnt_q     <= '0;
      still_cnt_q   <= '0;
      still_tot_q   <= '0;
      fall_count_q  <= '0;
      fall_sensor_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ff_cnt_q      <= ff_cnt_d;
      win_cnt_q     <= win_cnt_d;
      still_cnt_q   <= still_cnt_d;
      still_tot_q   <= still_tot_d;
      fall_count_q  <= fall_count_d;
      fall_sensor_q <= fall_sensor_d;
    end
  end

  assign fall_sensor = fall_sensor_q;
  assign fall_count  = fall_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fall_qualifier.sv
// Directed bench for fall_qualifier: vector table plus
// hand-written multi-sample fall sequences.
module tb_fall_qualifier;

  localparam int GAP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] accel_mag = '0;
  logic        clear = 1'b0;
  logic        fall_sensor;
  logic [7:0]  fall_count;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic       v;
    int         mag;
    logic       clr;
    logic [2:0] st;
    logic       fs;
  } vec_t;

  vec_t vecs[$];

  fall_qualifier dut (
    .clk(clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .accel_mag(accel_mag),
    .clear(clear),
    .fall_sensor(fall_sensor),
    .fall_count(fall_count),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic v, input int mag,
                     input logic clr, input logic [2:0] st);
    for (int i = 0; i < n; i++) vecs.push_back('{v, mag, clr, st, 1'b0});
  endtask

  // One strobe, then a gap; called and returns at a negedge
  task automatic send(input int mag, input logic clr = 1'b0);
    sample_valid = 1'b1;
    accel_mag = 12'(mag);
    clear = clr;
    @(negedge clk);
    sample_valid = 1'b0;
    clear = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic sendn(input int n, input int mag);
    for (int i = 0; i < n; i++) send(mag);
  endtask

  task automatic signature();
    sendn(10, 100);
    send(3000);
  endtask

  // Final still strobe: fall_sensor must still be low while the
  // strobe is presented and high one cycle later
  task automatic final_still(input int exp_cnt);
    sample_valid = 1'b1;
    accel_mag = 12'd1000;
    #1;
    check("fs_before_edge", int'(fall_sensor), 0);
    @(negedge clk);
    sample_valid = 1'b0;
    check("fs_rise", int'(fall_sensor), 1);
    check("fall_state", int'(state), 4);
    check("fall_count", int'(fall_count), exp_cnt);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_fs", int'(fall_sensor), 0);
    check("rst_count", int'(fall_count), 0);
    reset = 1'b1;
    @(negedge clk);

    // Per-cycle vectors: thresholds, short run, saturation, clear
    add(1, 1'b0, 100, 1'b0, 3'd0);
    add(1, 1'b1, 200, 1'b0, 3'd0);
    add(1, 1'b1, 199, 1'b0, 3'd1);
    add(4, 1'b1, 100, 1'b0, 3'd1);
    add(2, 1'b1, 3000, 1'b0, 3'd0);
    add(8, 1'b1, 150, 1'b0, 3'd1);
    add(1, 1'b0, 100, 1'b0, 3'd1);
    add(1, 1'b1, 2499, 1'b0, 3'd2);
    add(1, 1'b1, 2500, 1'b0, 3'd3);
    add(1, 1'b1, 1000, 1'b1, 3'd0);
    add(1, 1'b1, 1000, 1'b0, 3'd0);
    add(20, 1'b1, 100, 1'b0, 3'd1);
    add(1, 1'b1, 2500, 1'b0, 3'd3);
    add(1, 1'b0, 0, 1'b1, 3'd0);
    foreach (vecs[i]) begin
      sample_valid = vecs[i].v;
      accel_mag = 12'(vecs[i].mag);
      clear = vecs[i].clr;
      @(negedge clk);
      sample_valid = 1'b0;
      clear = 1'b0;
      check($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].st));
      check($sformatf("vec%0d_fs", i), int'(fall_sensor), int'(vecs[i].fs));
    end
    check("vec_count", int'(fall_count), 0);

    // Confirmed fall, still samples touching both band edges
    signature();
    for (int i = 0; i < 199; i++) send((i % 3 == 0) ? 700 : (i % 3 == 1) ? 1300 : 1000);
    check("cf_state_199", int'(state), 3);
    check("cf_fs_199", int'(fall_sensor), 0);
    final_still(1);
    sendn(3, 100);
    check("fall_hold_state", int'(state), 4);
    check("fall_hold_fs", int'(fall_sensor), 1);
    check("fall_hold_cnt", int'(fall_count), 1);

    // One-cycle clear releases the fall
    pulse_clear();
    check("clr_fs", int'(fall_sensor), 0);
    check("clr_state", int'(state), 0);
    check("clr_count", int'(fall_count), 1);
    repeat (GAP) @(negedge clk);

    // Short free-fall
    sendn(5, 100);
    send(3000);
    check("short_state", int'(state), 0);
    sendn(200, 1000);
    check("short_fs", int'(fall_sensor), 0);
    check("short_state2", int'(state), 0);

    // Impact window timeout
    sendn(10, 100);
    sendn(49, 1000);
    check("tmo_state_49", int'(state), 2);
    send(1000);
    check("tmo_state_50", int'(state), 0);
    send(3000);
    sendn(200, 1000);
    check("tmo_fs", int'(fall_sensor), 0);
    check("tmo_state", int'(state), 0);

    // Stillness restart after a just-outside sample
    signature();
    sendn(150, 1000);
    send(1301);
    sendn(199, 1000);
    check("rst350_state", int'(state), 3);
    check("rst350_fs", int'(fall_sensor), 0);
    final_still(2);
    pulse_clear();
    repeat (GAP) @(negedge clk);

    // Stillness window abort
    signature();
    for (int i = 1; i < 400; i++) send((i == 151) ? 1301 : (i == 302) ? 699 : 1000);
    check("abort_399", int'(state), 3);
    send(1000);
    check("abort_400", int'(state), 0);
    check("abort_fs", int'(fall_sensor), 0);
    check("abort_cnt", int'(fall_count), 2);

    // Clear coincident with a still sample; counters must restart
    signature();
    sendn(199, 1000);
    send(1000, 1'b1);
    check("clrmid_state", int'(state), 0);
    check("clrmid_fs", int'(fall_sensor), 0);
    send(1000);
    check("clrmid_state2", int'(state), 0);
    signature();
    sendn(199, 1000);
    check("clrmid_199", int'(state), 3);
    final_still(3);

    // Asynchronous reset between clock edges while in FALL
    #2;
    reset = 1'b0;
    #1;
    check("areset_fs", int'(fall_sensor), 0);
    check("areset_cnt", int'(fall_count), 0);
    check("areset_state", int'(state), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(100);
    check("post_rst_state", int'(state), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fall_qualifier.md
# fall_qualifier

Front-end qualification stage directly upstream of `fall_detection_system`. It consumes a strobed accelerometer magnitude stream and recognises the free-fall → impact → stillness signature of a real fall. On a confirmed fall it drives a held `fall_sensor` level into the alarm timer; the level is released by the same patient-reset pulse that feeds the alarm stage.

## Interface
- `MAG_W`, 12: width of the acceleration magnitude, in mg units.
- `FF_TH`, 200: free-fall threshold; a sample with magnitude strictly below it is free-fall.
- `IMPACT_TH`, 2500: impact threshold; a sample with magnitude at or above it is an impact.
- `ONE_G`, 1000: at-rest magnitude.
- `STILL_BAND`, 300: a sample is still if its magnitude is within ONE_G ± STILL_BAND, inclusive.
- `FF_MIN`, 8: minimum number of consecutive free-fall samples.
- `IMPACT_WIN`, 50: maximum number of samples allowed between the end of free-fall and the impact.
- `STILL_SAMPLES`, 200: number of consecutive still samples required to confirm a fall.
- `STILL_WIN`, 400: maximum number of samples spent in the stillness check before aborting.
- `clk` input 1: system clock (1 MHz).
- `reset` input 1: asynchronous, active-low reset.
- `sample_valid` input 1: one-cycle strobe marking `accel_mag` as valid (nominally 100 Hz).
- `accel_mag` input MAG_W: unsigned magnitude; only examined when `sample_valid` is 1.
- `clear` input 1: patient-reset pulse; wired in parallel with `patient_reset` of the alarm stage.
- `fall_sensor` output 1: registered; high while a confirmed fall is held.
- `fall_count` output 8: registered count of confirmed falls; saturates at 255.
- `state` output 3: current FSM state, for debug.

## Operation
- FSM states and encodings: IDLE=0, FREEFALL=1, IMPACT_WAIT=2, STILL_CHECK=3, FALL=4.
- Counters (`ff_cnt`, `win_cnt`, `still_cnt`, `still_tot`) change only on cycles where `sample_valid` is 1. The exception is `clear` and `reset`, which zero all counters.
- IDLE: on a free-fall sample, set `ff_cnt`=1 and go to FREEFALL.
- FREEFALL:
  - Free-fall sample: increment `ff_cnt`, saturating at FF_MIN.
  - Any other sample with `ff_cnt` < FF_MIN: go to IDLE.
  - Any other sample with `ff_cnt` ≥ FF_MIN and magnitude ≥ IMPACT_TH: go straight to STILL_CHECK.
  - Any other sample with `ff_cnt` ≥ FF_MIN and magnitude below IMPACT_TH: go to IMPACT_WAIT with `win_cnt`=1.
- IMPACT_WAIT:
  - Impact sample: go to STILL_CHECK with `still_cnt`=0 and `still_tot`=0.
  - Otherwise increment `win_cnt`; if `win_cnt` reaches IMPACT_WIN, go to IDLE.
- STILL_CHECK, on every sample:
  - Increment `still_tot`.
  - Still sample: increment `still_cnt`.
  - Non-still sample: set `still_cnt`=0.
  - If `still_cnt` reaches STILL_SAMPLES: go to FALL and increment `fall_count` (saturating).
  - Else if `still_tot` reaches STILL_WIN: go to IDLE.
- FALL: hold `fall_sensor`=1 and ignore samples. Leave only on `clear` or `reset`.
- `clear` in any state: next state is IDLE and all counters are zeroed. `clear` has priority over a sample on the same cycle. `fall_count` is not cleared.
- All threshold comparisons are unsigned at MAG_W bits.
  - The still band is computed at MAG_W+1 bits, with the lower bound clamped at 0.
  - Parameter legality: FF_TH < ONE_G−STILL_BAND and ONE_G+STILL_BAND < IMPACT_TH. This is checked at elaboration.

## Timing
- Reset (asynchronous, `reset`=0): state=IDLE, `fall_sensor`=0, `fall_count`=0, all counters 0.
- All outputs are registered; no combinational path from inputs to outputs.
- `fall_sensor` rises on the clock edge that samples the valid strobe completing the STILL_SAMPLES-th still sample. The downstream stage therefore sees it one cycle after that strobe.
- `fall_sensor` falls on the edge that samples `clear`=1. A one-cycle `clear` pulse is sufficient.
- A `sample_valid` held high for multiple cycles counts as one sample per cycle. No edge detection is applied.
- A free-fall run longer than FF_MIN keeps `ff_cnt` saturated and the state in FREEFALL. There is no timeout there.
- Reset asserted mid-sequence aborts immediately. The first post-reset sample is evaluated as in IDLE.

## Test plan
All scenarios use default parameters, with one sample every 10000 clocks.
- **Confirmed fall:** 10 samples at 100, then 1 at 3000, then 200 at 1000. Required: `fall_sensor`=1 one cycle after the 200th still strobe, `fall_count`=1, `state`=4.
- **Short free-fall:** 5 samples at 100, then 3000, then 200 at 1000. Required: `fall_sensor` stays 0 and `state` returns to 0 on the 3000 sample.
- **Impact timeout:** 10 samples at 100, then 50 at 1000 with no impact. Required: `state`=0 after the 50th sample. A later 3000 sample plus 200 at 1000 does not raise `fall_sensor`.
- **Stillness restart and abort:**
  - Fall signature, then 150 samples at 1000, 1 at 1500, then 200 at 1000: `fall_sensor` rises at total sample 351 of STILL_CHECK.
  - Same stimulus, but with the 1500 sample repeated every 150 samples: `state`=0 at `still_tot`=400.
- **Clear behaviour:**
  - In FALL, a one-cycle `clear`: `fall_sensor`=0 on the next cycle, `state`=0, `fall_count` unchanged.
  - `clear` coincident with a sample mid-STILL_CHECK: returns to IDLE and the sample is ignored.
- **Async reset mid-FALL:** drive `reset`=0 between clock edges. Required: `fall_sensor` and `fall_count` go to 0 immediately, without waiting for a clock edge.
